// File: rtl/pmp_chk_arb_pkg.sv
// Shared PMP definitions: access-mode encoding and per-entry configuration layout.
package pmp_chk_arb_pkg;

  typedef enum logic [1:0] {
    PMP_ACC_NONE  = 2'b00,
    PMP_ACC_LOAD  = 2'b01,
    PMP_ACC_STORE = 2'b10,
    PMP_ACC_FETCH = 2'b11
  } pmp_acc_e;

  typedef enum logic [1:0] {
    PMP_A_OFF   = 2'b00,
    PMP_A_TOR   = 2'b01,
    PMP_A_NA4   = 2'b10,
    PMP_A_NAPOT = 2'b11
  } pmp_amatch_e;

  typedef struct packed {
    logic        lock;
    logic [1:0]  rsvd;
    pmp_amatch_e amatch;
    logic        x;
    logic        w;
    logic        r;
  } pmp_cfg_t;

  // Mode 00 carries no access and must never be reported as permitted.
  function automatic logic acc_valid(input pmp_acc_e m);
    return m != PMP_ACC_NONE;
  endfunction

endpackage

// File: rtl/pmp_chk_arb_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr.
module rr_arb #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt
);

  localparam int unsigned PW = $clog2(N);

  always_comb begin
    logic          found;
    logic [PW-1:0] idx;
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PW'((32'(ptr) + k) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pmp_chk_arb.sv
// Shares one PMP compare channel between REQ_NUM requesters through a two-stage
// CHK/RSP pipeline with round-robin admission and a saturating deny counter.
module pmp_chk_arb
  import pmp_chk_arb_pkg::*;
#(
  parameter int unsigned REQ_NUM    = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [REQ_NUM-1:0]            v_req_vld,
  input  logic [ADDR_WIDTH*REQ_NUM-1:0] v_req_addr,
  input  logic [2*REQ_NUM-1:0]          v_req_mode,
  output logic [REQ_NUM-1:0]            v_req_rdy,
  output logic [REQ_NUM-1:0]            v_rsp_vld,
  output logic                          rsp_pass,
  input  logic [REQ_NUM-1:0]            v_rsp_rdy,
  output logic [ADDR_WIDTH-1:0]         chk_addr,
  output logic [1:0]                    chk_mode,
  input  logic                          chk_pass,
  input  logic                          flush,
  output logic [CNT_WIDTH-1:0]          deny_cnt
);

  localparam int unsigned IDW = $clog2(REQ_NUM);

  logic                  chk_vld;
  logic [ADDR_WIDTH-1:0] chk_addr_q;
  pmp_acc_e              chk_mode_q;
  logic [IDW-1:0]        chk_id;
  logic                  rsp_vld;
  logic                  rsp_pass_q;
  logic [IDW-1:0]        rsp_id;
  logic [IDW-1:0]        rr_ptr;
  logic [CNT_WIDTH-1:0]  deny_q;

  logic [REQ_NUM-1:0]    gnt;
  logic [IDW-1:0]        gnt_id;
  logic                  rsp_fire;
  logic                  rsp_free;
  logic                  chk_adv;
  logic                  chk_free;
  logic                  accept;
  logic                  xfer;
  logic                  chk_pass_eff;

  rr_arb #(.N(REQ_NUM)) u_rr_arb (
    .req (v_req_vld),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  always_comb begin
    gnt_id = '0;
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      if (gnt[i]) gnt_id = IDW'(i);
    end
  end

  // Free-slot chain runs back to front so a draining RSP lets CHK and a new
  // request move in the same cycle.
  assign rsp_fire     = rsp_vld && v_rsp_rdy[rsp_id];
  assign rsp_free     = !rsp_vld || rsp_fire;
  assign chk_adv      = chk_vld && rsp_free;
  assign chk_free     = !chk_vld || chk_adv;
  assign accept       = rst_n && !flush && chk_free && (|gnt);
  assign xfer         = chk_adv && !flush;
  assign chk_pass_eff = chk_pass && acc_valid(chk_mode_q);

  assign v_req_rdy = accept ? gnt : '0;
  assign chk_addr  = chk_vld ? chk_addr_q : '0;
  assign chk_mode  = chk_vld ? chk_mode_q : PMP_ACC_NONE;
  assign rsp_pass  = rsp_vld && rsp_pass_q;
  assign deny_cnt  = deny_q;

  always_comb begin
    v_rsp_vld = '0;
    if (rsp_vld) v_rsp_vld[rsp_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chk_vld <= 1'b0;
      rsp_vld <= 1'b0;
      rr_ptr  <= '0;
      deny_q  <= '0;
    end else begin
      if (flush) begin
        chk_vld <= 1'b0;
        rsp_vld <= 1'b0;
      end else begin
        if (chk_adv)       rsp_vld <= 1'b1;
        else if (rsp_fire) rsp_vld <= 1'b0;
        if (accept)        chk_vld <= 1'b1;
        else if (chk_adv)  chk_vld <= 1'b0;
      end
      if (accept) begin
        rr_ptr <= (32'(gnt_id) == REQ_NUM - 1) ? '0 : gnt_id + 1'b1;
      end
      if (xfer && acc_valid(chk_mode_q) && !chk_pass && (deny_q != '1)) begin
        deny_q <= deny_q + 1'b1;
      end
    end
  end

  // Payload registers are qualified by the valid bits above and need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      chk_addr_q <= v_req_addr[32'(gnt_id) * ADDR_WIDTH +: ADDR_WIDTH];
      chk_mode_q <= pmp_acc_e'(v_req_mode[32'(gnt_id) * 2 +: 2]);
      chk_id     <= gnt_id;
    end
    if (chk_adv) begin
      rsp_pass_q <= chk_pass_eff;
      rsp_id     <= chk_id;
    end
  end

endmodule

// File: doc/pmp_chk_arb.md
PMP_CHK_ARB -- requirements
Module: pmp_chk_arb

Interface
REQ-001 Parameter REQ_NUM, default 4: number of requesters sharing one PMP compare channel (2..8).
REQ-002 Parameter ADDR_WIDTH, default 32: physical address width.
REQ-003 Parameter CNT_WIDTH, default 16: width of the deny counter.
REQ-004 The block SHALL use one clock; reset is synchronous and active-low.
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
REQ-005 The block SHALL have the following requester ports:
- v_req_vld  input  REQ_NUM  request valid per requester.
- v_req_addr  input  ADDR_WIDTH x REQ_NUM  address to check.
- v_req_mode  input  2 x REQ_NUM  access mode: 01 load, 10 store, 11 fetch.
- v_req_rdy  output  REQ_NUM  request accepted this cycle (one-hot or zero).
REQ-006 The block SHALL have the following response ports:
- v_rsp_vld  output  REQ_NUM  response valid, one-hot to the owning requester.
- rsp_pass  output  1  check result for the valid response.
- v_rsp_rdy  input  REQ_NUM  response consumed per requester.
REQ-007 The block SHALL have the following compare-channel and control ports:
- chk_addr  output  ADDR_WIDTH  address to pmp_compare.
- chk_mode  output  2  mode to pmp_compare.
- chk_pass  input  1  combinational pass from pmp_compare.
- flush  input  1  discard all in-flight requests.
- deny_cnt  output  CNT_WIDTH  saturating count of failed checks.

Function
REQ-008 The pipeline SHALL have two one-entry stages: CHK (addr, mode, id, valid) and RSP (pass, id, valid).
REQ-009 Grant: among set v_req_vld bits, the block SHALL grant one requester per cycle, round-robin, starting at pointer rr_ptr.
REQ-010 After a grant to requester i, rr_ptr SHALL become (i+1) mod REQ_NUM; with no grant, rr_ptr SHALL hold.
REQ-011 v_req_rdy[i] SHALL assert only when i is granted, flush=0, and CHK is empty or advancing this cycle; the request is accepted on that edge.
REQ-012 chk_addr/chk_mode SHALL be driven from the CHK register; while CHK is empty they SHALL be 0.
REQ-013 CHK SHALL advance into RSP when RSP is empty or its response is consumed this cycle; RSP.pass SHALL capture chk_pass, forced to 0 if CHK.mode=00.
REQ-014 Latency SHALL be exactly 2 cycles: a request accepted at edge N gives v_rsp_vld at cycle N+2 when there is no backpressure.
REQ-015 With no backpressure, throughput SHALL be one request per cycle (back-to-back accept while RSP drains in the same cycle).
REQ-016 v_rsp_vld[RSP.id] SHALL be asserted while RSP is valid; RSP SHALL hold stable until v_rsp_rdy[RSP.id]=1.
REQ-017 v_rsp_rdy bits of non-owning requesters SHALL be ignored.
REQ-018 Backpressure: a held RSP SHALL stall CHK, and a held CHK SHALL deassert all v_req_rdy; no entry SHALL be dropped or duplicated.
REQ-019 flush=1 SHALL clear CHK and RSP valid at the next edge, block acceptance that cycle, and leave rr_ptr unchanged.
REQ-020 A response handshake in the same cycle as flush SHALL still count as consumed.
REQ-021 deny_cnt SHALL increment by 1 on each CHK->RSP transfer with pass=0, and SHALL saturate at all-ones.
REQ-022 deny_cnt SHALL NOT count flushed entries or mode-00 entries.

Reset
REQ-023 On rst_n=0 at a clk edge: CHK and RSP valid SHALL be 0, rr_ptr SHALL be 0, and deny_cnt SHALL be 0.
REQ-024 During reset, all outputs SHALL read 0 from the cycle after the reset edge.
REQ-025 Reset asserted mid-operation SHALL discard in-flight entries without emitting responses.

Structure
REQ-026 The access-mode encoding (LOAD=01, STORE=10, FETCH=11) SHALL be defined in the shared PMP package alongside the PMP config typedef, and SHALL not be redefined locally.
REQ-027 The round-robin grant logic SHALL be the sub-module rr_arb (parameter N; inputs: req vector, pointer; output: one-hot grant).
REQ-028 pmp_compare SHALL be instantiated outside this block and connected through the chk_* ports.

Verification
REQ-029 Single request: req0 addr=0x8000_0000, mode=01, chk_pass=1 -> v_rsp_vld=0001 at N+2, rsp_pass=1, deny_cnt=0.
REQ-030 All four requesting continuously with rsp_rdy all 1 -> grants 0,1,2,3,0 on consecutive cycles; one response per cycle.
REQ-031 Backpressure: v_rsp_rdy[2]=0 for 5 cycles with 3 requests queued -> RSP holds stable, v_req_rdy=0 after CHK fills, no loss when released.
REQ-032 Flush with CHK and RSP both valid -> no v_rsp_vld the next cycle, rr_ptr unchanged, next grant follows rr_ptr.
REQ-033 Deny saturation: CNT_WIDTH=4, 17 failing checks -> deny_cnt=0xF; a mode-00 request -> rsp_pass=0 and deny_cnt unchanged.
REQ-034 Reset mid-stream with 2 entries in flight -> all outputs 0, no response emitted, and the first post-reset grant goes to requester 0.
